pipe_hazard_ctrl: RTL and testbench

//  Sequences the 4-stage pipeline (IF -> ID -> EXMEM -> WB) by driving stage-register enables and bubble/flush

---
 rtl/pipe_hazard_ctrl_pkg.sv | 41 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM states, writeback selects, stage-control bundle.
// Imported by the hazard comparator and the sequencing FSM.
package pipe_defs;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  // Writeback mux selects; SEL_MEM marks the EXMEM instruction as a load.
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exwb;
    logic flush_ifid;
    logic flush_idex;
  } ctrl_t;

  function automatic ctrl_t ctrl_all_en(input logic flush_ifid, input logic flush_idex);
    ctrl_t c;
    c.en_pc      = 1'b1;
    c.en_ifid    = 1'b1;
    c.en_idex    = 1'b1;
    c.en_exwb    = 1'b1;
    c.flush_ifid = flush_ifid;
    c.flush_idex = flush_idex;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: flags an ID source register that matches a load's destination in EXMEM.
// Purely combinational.
module hazard_detect
  import pipe_defs::*;
#(
  parameter logic [1:0] LOAD_SEL = SEL_MEM
) (
  input  logic [REG_W-1:0] id_ra_i,
  input  logic [REG_W-1:0] id_rb_i,
  input  logic             id_use_ra_i,
  input  logic             id_use_rb_i,
  input  logic [REG_W-1:0] ex_wc_i,
  input  logic             ex_w_rb_i,
  input  logic [1:0]       ex_s_mxrb_i,
  output logic             lu_hazard_o
);

  logic ex_is_load;
  logic ra_hit;
  logic rb_hit;

  assign ex_is_load  = ex_w_rb_i & (ex_s_mxrb_i == LOAD_SEL);
  assign ra_hit      = id_use_ra_i & (id_ra_i == ex_wc_i);
  assign rb_hit      = id_use_rb_i & (id_rb_i == ex_wc_i);
  assign lu_hazard_o = ex_is_load & (ra_hit | rb_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing FSM for the IF/ID/EXMEM/WB pipeline: stage enables, bubbles, squash, memory wait,
// halt/drain/resume. Controls are combinational from registered state and take effect on the next edge.
module pipe_hazard_ctrl
  import pipe_defs::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter int         CNT_W       = 16,
  parameter logic [1:0] LOAD_SEL    = 2'b01
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [REG_W-1:0] id_RA,
  input  logic [REG_W-1:0] id_RB,
  input  logic             id_use_RA,
  input  logic             id_use_RB,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_WC,
  input  logic             ex_W_RB,
  input  logic [1:0]       ex_S_MXRB,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             resume,
  output logic             EN_PC,
  output logic             EN_IFID,
  output logic             EN_IDEX,
  output logic             EN_EXWB,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       drain_q, drain_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q;

  ctrl_t ctrl_fsm;
  ctrl_t ctrl;
  logic  lu_hazard;
  logic  mem_stall;

  hazard_detect #(.LOAD_SEL(LOAD_SEL)) u_hazard (
    .id_ra_i     (id_RA),
    .id_rb_i     (id_RB),
    .id_use_ra_i (id_use_RA),
    .id_use_rb_i (id_use_RB),
    .ex_wc_i     (ex_WC),
    .ex_w_rb_i   (ex_W_RB),
    .ex_s_mxrb_i (ex_S_MXRB),
    .lu_hazard_o (lu_hazard)
  );

  // An ack with no outstanding request never releases anything.
  assign mem_stall = mem_req & ~mem_ack;

  always_comb begin
    ctrl_fsm = '0;
    state_d  = state_q;
    wait_d   = wait_q;
    drain_d  = drain_q;
    err_d    = err_q;

    unique case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_q == TIMEOUT) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = ST_HALTED;
          end else begin
            wait_d  = wait_q + 8'd1;
            state_d = ST_MEM_WAIT;
          end
        end else begin
          wait_d  = '0;
          state_d = ST_RUN;
          if (ex_br_taken) begin
            ctrl_fsm = ctrl_all_en(1'b1, 1'b1);
          end else if (lu_hazard) begin
            ctrl_fsm.en_idex    = 1'b1;
            ctrl_fsm.en_exwb    = 1'b1;
            ctrl_fsm.flush_idex = 1'b1;
          end else if (id_halt) begin
            ctrl_fsm = ctrl_all_en(1'b1, 1'b0);
            drain_d  = '0;
            state_d  = ST_DRAIN;
          end else begin
            ctrl_fsm = ctrl_all_en(1'b0, 1'b0);
          end
        end
      end

      ST_DRAIN: begin
        if (mem_stall) begin
          if (wait_q == TIMEOUT) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = ST_HALTED;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          wait_d              = '0;
          ctrl_fsm.en_idex    = 1'b1;
          ctrl_fsm.en_exwb    = 1'b1;
          ctrl_fsm.flush_ifid = 1'b1;
          ctrl_fsm.flush_idex = 1'b1;
          // Two advancing cycles push HALT out of EXMEM and through WB.
          if (drain_q == 2'd1) begin
            drain_d = '0;
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
      end

      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // Reset overrides everything asynchronously: freeze all stages and bubble both registers.
  always_comb begin
    ctrl = ctrl_fsm;
    if (!RESET) begin
      ctrl            = '0;
      ctrl.flush_ifid = 1'b1;
      ctrl.flush_idex = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      if (!ctrl.en_pc && (state_q != ST_HALTED) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign EN_PC       = ctrl.en_pc;
  assign EN_IFID     = ctrl.en_ifid;
  assign EN_IDEX     = ctrl.en_idex;
  assign EN_EXWB     = ctrl.en_exwb;
  assign FLUSH_IFID  = ctrl.flush_ifid;
  assign FLUSH_IDEX  = ctrl.flush_idex;
  assign halted      = (state_q == ST_HALTED);
  assign mem_err     = err_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed enables/flushes, counters and status per step.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  id_RA, id_RB, ex_WC;
  logic        id_use_RA, id_use_RB, id_halt, ex_W_RB, ex_br_taken;
  logic [1:0]  ex_S_MXRB;
  logic        mem_req, mem_ack, resume;
  logic        EN_PC, EN_IFID, EN_IDEX, EN_EXWB, FLUSH_IFID, FLUSH_IDEX;
  logic        halted, mem_err;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // {EN_PC, EN_IFID, EN_IDEX, EN_EXWB, FLUSH_IFID, FLUSH_IDEX}
  localparam logic [5:0] C_RUN   = 6'b1111_00;
  localparam logic [5:0] C_FRZ   = 6'b0000_00;
  localparam logic [5:0] C_RST   = 6'b0000_11;
  localparam logic [5:0] C_LU    = 6'b0011_01;
  localparam logic [5:0] C_BR    = 6'b1111_11;
  localparam logic [5:0] C_HALT  = 6'b1111_10;
  localparam logic [5:0] C_DRAIN = 6'b0011_11;

  wire [5:0] ctrl_obs = {EN_PC, EN_IFID, EN_IDEX, EN_EXWB, FLUSH_IFID, FLUSH_IDEX};

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .id_RA(id_RA), .id_RB(id_RB), .id_use_RA(id_use_RA), .id_use_RB(id_use_RB),
    .id_halt(id_halt), .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack), .resume(resume),
    .EN_PC(EN_PC), .EN_IFID(EN_IFID), .EN_IDEX(EN_IDEX), .EN_EXWB(EN_EXWB),
    .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX),
    .halted(halted), .mem_err(mem_err), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_RA = 4'd0; id_RB = 4'd0; id_use_RA = 1'b0; id_use_RB = 1'b0; id_halt = 1'b0;
    ex_WC = 4'd0; ex_W_RB = 1'b0; ex_S_MXRB = 2'b00; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; resume = 1'b0;
  endtask

  // Advance one edge; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    tick();
  endtask

  task automatic set_load_r3();
    ex_W_RB = 1'b1; ex_S_MXRB = 2'b01; ex_WC = 4'd3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    RESET = 1'b0;
    #2;
    chk("rst_ctrl", 32'(ctrl_obs), 32'(C_RST));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    settle();
    chk("idle_ctrl", 32'(ctrl_obs), 32'(C_RUN));

    // Load-use on RA: one bubble, then free-running.
    set_load_r3(); id_RA = 4'd3; id_use_RA = 1'b1;
    settle();
    chk("lu_ra_ctrl", 32'(ctrl_obs), 32'(C_LU));
    tick();
    clear_inputs();
    settle();
    chk("lu_after_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    chk("lu_stall", 32'(stall_count), 32'd1);
    tick();
    // Load-use on RB only.
    set_load_r3(); id_RB = 4'd3; id_use_RB = 1'b1; id_RA = 4'd3;
    settle();
    chk("lu_rb_ctrl", 32'(ctrl_obs), 32'(C_LU));
    // Matching register but not read.
    id_use_RB = 1'b0;
    settle();
    chk("lu_nouse_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    // Read matches but EXMEM instr is an ALU op, not a load.
    id_use_RA = 1'b1; ex_S_MXRB = 2'b00;
    settle();
    chk("lu_alu_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    // Load whose result is not written back.
    ex_S_MXRB = 2'b01; ex_W_RB = 1'b0;
    settle();
    chk("lu_nowrite_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    tick();
    chk("lu_stall_hold", 32'(stall_count), 32'd1);

    // Memory wait released by ack on the 4th cycle.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_freeze_ctrl", 32'(ctrl_obs), 32'(C_FRZ));
      tick();
    end
    mem_ack = 1'b1;
    settle();
    chk("mw_ack_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    tick();
    clear_inputs();
    settle();
    chk("mw_stall", 32'(stall_count), 32'd3);
    chk("mw_halted", 32'(halted), 32'd0);
    // Ack with no request is ignored.
    mem_ack = 1'b1;
    settle();
    chk("ack_noreq_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    tick();
    clear_inputs();

    // Memory timeout: 1 entry cycle + 15 wait cycles, then HALTED with sticky error.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      settle();
      chk("to_freeze_ctrl", 32'(ctrl_obs), 32'(C_FRZ));
      tick();
    end
    chk("to_not_yet_err", 32'(mem_err), 32'd0);
    chk("to_not_yet_halted", 32'(halted), 32'd0);
    tick();
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_stall", 32'(stall_count), 32'd16);
    mem_req = 1'b0;
    settle();
    chk("halted_ctrl", 32'(ctrl_obs), 32'(C_FRZ));
    tick();
    chk("halted_stall_hold", 32'(stall_count), 32'd16);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    settle();
    chk("to_resume_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    chk("to_resume_halted", 32'(halted), 32'd0);
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    tick();

    // Branch outranks load-use and halt.
    do_reset();
    ex_br_taken = 1'b1; id_halt = 1'b1;
    set_load_r3(); id_RA = 4'd3; id_use_RA = 1'b1;
    settle();
    chk("br_ctrl", 32'(ctrl_obs), 32'(C_BR));
    tick();
    clear_inputs();
    settle();
    chk("br_after_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    chk("br_stall", 32'(stall_count), 32'd0);
    // Stray resume in RUN does nothing.
    resume = 1'b1;
    settle();
    chk("resume_run_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    tick();
    resume = 1'b0;

    // Halt: fetch stops, two drain cycles, then HALTED until resume.
    do_reset();
    id_halt = 1'b1;
    settle();
    chk("halt_ctrl", 32'(ctrl_obs), 32'(C_HALT));
    tick();
    id_halt = 1'b0;
    settle();
    chk("drain1_ctrl", 32'(ctrl_obs), 32'(C_DRAIN));
    chk("drain1_halted", 32'(halted), 32'd0);
    tick();
    settle();
    chk("drain2_ctrl", 32'(ctrl_obs), 32'(C_DRAIN));
    tick();
    settle();
    chk("drain_halted", 32'(halted), 32'd1);
    chk("drain_halt_ctrl", 32'(ctrl_obs), 32'(C_FRZ));
    chk("drain_stall", 32'(stall_count), 32'd2);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    settle();
    chk("drain_resume_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    chk("drain_resume_halted", 32'(halted), 32'd0);
    tick();

    // Memory freeze inside DRAIN holds the drain count.
    do_reset();
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0; mem_req = 1'b1;
    settle();
    chk("drain_mw_ctrl", 32'(ctrl_obs), 32'(C_FRZ));
    tick();
    mem_ack = 1'b1;
    settle();
    chk("drain_mw_ack_ctrl", 32'(ctrl_obs), 32'(C_DRAIN));
    tick();
    clear_inputs();
    settle();
    chk("drain_mw_2nd_ctrl", 32'(ctrl_obs), 32'(C_DRAIN));
    chk("drain_mw_not_halted", 32'(halted), 32'd0);
    tick();
    chk("drain_mw_halted", 32'(halted), 32'd1);
    chk("drain_mw_stall", 32'(stall_count), 32'd3);

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    mem_req = 1'b1;
    tick();
    tick();
    settle();
    chk("arst_pre_ctrl", 32'(ctrl_obs), 32'(C_FRZ));
    RESET = 1'b0;
    #1;
    chk("arst_ctrl", 32'(ctrl_obs), 32'(C_RST));
    chk("arst_stall", 32'(stall_count), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    mem_req = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    settle();
    chk("arst_release_ctrl", 32'(ctrl_obs), 32'(C_RUN));
    chk("arst_release_stall", 32'(stall_count), 32'd0);
    chk("arst_release_err", 32'(mem_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
